// File: rtl/cp0_tlb_regs.sv
// cp0_tlb_regs: CP0 TLB register file and TLBR/TLBWI/TLBWR/TLBP sequencer
module cp0_tlb_regs #(
  parameter int NUM_ENTRIES  = 16,
  parameter int RANDOM_RESET = 15,
  localparam int IW = $clog2(NUM_ENTRIES)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tlb_op_valid,
  input  logic [1:0]     tlb_op,
  output logic           tlb_op_ready,
  output logic           tlb_op_done,
  input  logic           mtc0_we,
  input  logic [4:0]     mtc0_addr,
  input  logic [31:0]    mtc0_data,
  input  logic [4:0]     mfc0_addr,
  output logic [31:0]    mfc0_data,
  input  logic           exc_tlb_we,
  input  logic [31:0]    exc_vaddr,
  output logic [79+IW:0] tlb_config,
  output logic           tlbwi,
  output logic           tlbp,
  output logic [IW-1:0]  tlb_rd_index,
  input  logic [79:0]    tlb_rd_entry,
  input  logic [31:0]    tlbp_result,
  output logic [7:0]     asid
);
  localparam logic [IW-1:0] RR = IW'(RANDOM_RESET);
  typedef enum logic [1:0] {IDLE, WRITE, READ, PROBE} state_t;
  state_t state, state_nx;
  logic [1:0] op_q;
  logic index_p;
  logic [IW-1:0] index_idx, random, wired, cfg_idx;
  logic [18:0] vpn2;
  logic [7:0] asid_r;
  logic [29:0] lo0, lo1;
  logic wr_index, wr_lo0, wr_lo1, wr_wired, wr_hi;
  logic unused;
  assign unused = ^{tlbp_result[30:IW], exc_vaddr[12:0], mtc0_data[12:8]};
  assign wr_index = mtc0_we && mtc0_addr == 5'd0;
  assign wr_lo0 = mtc0_we && mtc0_addr == 5'd2;
  assign wr_lo1 = mtc0_we && mtc0_addr == 5'd3;
  assign wr_wired = mtc0_we && mtc0_addr == 5'd6;
  assign wr_hi = mtc0_we && mtc0_addr == 5'd10;
  // Sequencer state and the op latched at acceptance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op_q <= 2'b00;
    end else begin
      state <= state_nx;
      if (state == IDLE && tlb_op_valid) op_q <= tlb_op;
    end
  // Every non-idle state lasts one cycle and returns to IDLE
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE && tlb_op_valid)
      state_nx = tlb_op == 2'b00 ? READ : tlb_op == 2'b11 ? PROBE : WRITE;
  end
  assign tlb_op_ready = state == IDLE;
  assign tlb_op_done = state != IDLE;
  assign tlbwi = state == WRITE;
  assign tlbp = state == PROBE;
  assign tlb_rd_index = index_idx;
  assign asid = asid_r;
  assign cfg_idx = op_q == 2'b10 ? random : index_idx;
  assign tlb_config = {asid_r, lo0[0] & lo1[0], vpn2, lo1[29:6], lo1[2:1], lo0[29:6], lo0[2:1], cfg_idx};
  // Index: probe capture overrides software; P is hardware-only
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      index_p <= 1'b0;
      index_idx <= '0;
    end else if (state == PROBE) begin
      index_p <= tlbp_result[31];
      index_idx <= tlbp_result[IW-1:0];
    end else if (wr_index) index_idx <= mtc0_data[IW-1:0];
  // EntryHi: TLBR load, then exception VPN2 capture, then software
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vpn2 <= '0;
      asid_r <= '0;
    end else if (state == READ) begin
      vpn2 <= tlb_rd_entry[70:52];
      asid_r <= tlb_rd_entry[79:72];
    end else if (exc_tlb_we) vpn2 <= exc_vaddr[31:13];
    else if (wr_hi) begin
      vpn2 <= mtc0_data[31:13];
      asid_r <= mtc0_data[7:0];
    end
  // EntryLo0/1: TLBR load clears C and duplicates the shared G bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lo0 <= '0;
      lo1 <= '0;
    end else if (state == READ) begin
      lo0 <= {tlb_rd_entry[25:2], 3'b000, tlb_rd_entry[1:0], tlb_rd_entry[71]};
      lo1 <= {tlb_rd_entry[51:28], 3'b000, tlb_rd_entry[27:26], tlb_rd_entry[71]};
    end else begin
      if (wr_lo0) lo0 <= mtc0_data[29:0];
      if (wr_lo1) lo1 <= mtc0_data[29:0];
    end
  // Wired and the Random replacement pointer that cycles down to Wired
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wired <= '0;
      random <= RR;
    end else begin
      if (wr_wired) wired <= mtc0_data[IW-1:0];
      random <= wr_wired || random <= wired ? RR : random - 1'b1;
    end
  assign mfc0_data = mfc0_addr == 5'd0  ? {index_p, {(31-IW){1'b0}}, index_idx} :
                     mfc0_addr == 5'd1  ? {{(32-IW){1'b0}}, random} :
                     mfc0_addr == 5'd2  ? {2'b00, lo0} :
                     mfc0_addr == 5'd3  ? {2'b00, lo1} :
                     mfc0_addr == 5'd6  ? {{(32-IW){1'b0}}, wired} :
                     mfc0_addr == 5'd10 ? {vpn2, 5'b00000, asid_r} : 32'h0;
endmodule

// File: tb/tb_cp0_tlb_regs.sv
// tb_cp0_tlb_regs: directed self-checking bench for cp0_tlb_regs
module tb_cp0_tlb_regs;
  logic clk = 0, rst_n = 0;
  logic tlb_op_valid = 0, tlb_op_ready, tlb_op_done;
  logic [1:0] tlb_op = 0;
  logic mtc0_we = 0;
  logic [4:0] mtc0_addr = 0, mfc0_addr = 0;
  logic [31:0] mtc0_data = 0, mfc0_data, exc_vaddr = 0, tlbp_result = 0;
  logic exc_tlb_we = 0, tlbwi, tlbp;
  logic [83:0] tlb_config;
  logic [3:0] tlb_rd_index, first_idx;
  logic [79:0] tlb_rd_entry = 0;
  logic [7:0] asid;
  int checks = 0, errors = 0;
  cp0_tlb_regs dut (
    .clk(clk), .rst_n(rst_n), .tlb_op_valid(tlb_op_valid), .tlb_op(tlb_op),
    .tlb_op_ready(tlb_op_ready), .tlb_op_done(tlb_op_done), .mtc0_we(mtc0_we),
    .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data), .mfc0_addr(mfc0_addr),
    .mfc0_data(mfc0_data), .exc_tlb_we(exc_tlb_we), .exc_vaddr(exc_vaddr),
    .tlb_config(tlb_config), .tlbwi(tlbwi), .tlbp(tlbp), .tlb_rd_index(tlb_rd_index),
    .tlb_rd_entry(tlb_rd_entry), .tlbp_result(tlbp_result), .asid(asid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [83:0] got, input logic [83:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    mfc0_addr = a;
    #1;
    check(tag, mfc0_data, exp);
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1;
    mtc0_addr = a;
    mtc0_data = d;
    @(negedge clk);
    mtc0_we = 0;
  endtask
  task automatic op(input logic [1:0] o);
    tlb_op_valid = 1;
    tlb_op = o;
    @(negedge clk);
    tlb_op_valid = 0;
    mtc0_we = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    check("rst_ready", tlb_op_ready, 1);
    check("rst_done", tlb_op_done, 0);
    check("rst_tlbwi", tlbwi, 0);
    check("rst_tlbp", tlbp, 0);
    rd("rst_random", 1, 15);
    rd("rst_wired", 6, 0);
    rd("rst_index", 0, 0);
    rd("rst_hi", 10, 0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      rd("rand_count", 1, 32'(15 - k));
    end
    @(negedge clk);
    rd("rand_wrap", 1, 15);
    wr(6, 4);
    rd("wired4_reload", 1, 15);
    rd("wired4_val", 6, 4);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      rd("wired4_count", 1, 32'(15 - k));
    end
    @(negedge clk);
    rd("wired4_wrap", 1, 15);
    wr(10, 32'h0000_2005);
    wr(2, 32'h0000_0047);
    wr(3, 32'h0000_0087);
    check("wi_ready", tlb_op_ready, 1);
    mtc0_we = 1;
    mtc0_addr = 0;
    mtc0_data = 3;
    op(1);
    check("wi_strobe", tlbwi, 1);
    check("wi_done", tlb_op_done, 1);
    check("wi_busy", tlb_op_ready, 0);
    check("wi_noprobe", tlbp, 0);
    check("wi_config", tlb_config, {8'h05, 1'b1, 19'd1, 24'd2, 2'b11, 24'd1, 2'b11, 4'd3});
    @(negedge clk);
    check("wi_strobe_end", tlbwi, 0);
    check("wi_done_end", tlb_op_done, 0);
    check("wi_ready_end", tlb_op_ready, 1);
    wr(10, 0);
    wr(2, 32'h38);
    wr(3, 0);
    check("g_and", tlb_config[75], 0);
    tlb_rd_entry = {8'h05, 1'b1, 19'd1, 24'd2, 2'b11, 24'd1, 2'b11};
    check("rd_index", tlb_rd_index, 3);
    op(0);
    check("r_done", tlb_op_done, 1);
    check("r_nowrite", tlbwi, 0);
    @(negedge clk);
    rd("r_hi", 10, 32'h0000_2005);
    rd("r_lo1", 3, 32'h0000_0087);
    rd("r_lo0", 2, 32'h0000_0047);
    check("r_asid", asid, 8'h05);
    exc_tlb_we = 1;
    exc_vaddr = 32'hABCD_E123;
    wr(10, 32'h1234_5677);
    exc_tlb_we = 0;
    rd("exc_wins", 10, 32'hABCD_E005);
    tlbp_result = 32'h0000_0007;
    op(3);
    check("p_strobe", tlbp, 1);
    check("p_done", tlb_op_done, 1);
    @(negedge clk);
    check("p_strobe_end", tlbp, 0);
    rd("p_hit", 0, 32'h0000_0007);
    tlbp_result = 32'h8000_0000;
    op(3);
    @(negedge clk);
    rd("p_miss", 0, 32'h8000_0000);
    wr(0, 32'h0000_000F);
    rd("idx_keep_p", 0, 32'h8000_000F);
    rd("unmapped", 5, 0);
    wr(6, 2);
    op(2);
    check("wr_strobe", tlbwi, 1);
    check("wr_idx1", tlb_config[3:0], 14);
    first_idx = tlb_config[3:0];
    repeat (4) @(negedge clk);
    op(2);
    check("wr_idx2", tlb_config[3:0], 9);
    check("wr_differ", first_idx != tlb_config[3:0], 1);
    @(negedge clk);
    op(1);
    rst_n = 0;
    #1;
    check("arst_tlbwi", tlbwi, 0);
    check("arst_done", tlb_op_done, 0);
    check("arst_ready", tlb_op_ready, 1);
    rd("arst_random", 1, 15);
    rd("arst_index", 0, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("arst_idle", tlb_op_done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
